// File: rtl/mc_bus_regif_if.sv
// ============================================================================
// Module : mc_bus_regif_if
// Brief  : MCU parallel memory bus bundle (strobes, address, split data path).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_bus_regif_if #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6
);
    logic                     mc_ce;
    logic                     mc_we;
    logic                     mc_oe;
    logic [MC_ADD_WIDTH-1:0]  mc_add;
    logic [MC_DATA_WIDTH-1:0] mc_data_i;
    logic [MC_DATA_WIDTH-1:0] mc_data_o;
    logic                     mc_data_oe;

    modport master (
        output mc_ce, mc_we, mc_oe, mc_add, mc_data_i,
        input  mc_data_o, mc_data_oe
    );

    modport slave (
        input  mc_ce, mc_we, mc_oe, mc_add, mc_data_i,
        output mc_data_o, mc_data_oe
    );
endinterface

`default_nettype wire

// File: rtl/mc_bus_regif.sv
// ============================================================================
// Module : mc_bus_regif
// Brief  : MCU bus front-end: strobe sync, config/status regs, FIFO ports.
//          Optional macro MC_BUS_ERRCNT_EN adds a saturating error counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_bus_regif #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int REG_COUNT     = 8
) (
    input  wire logic                               clk,
    input  wire logic                               rst,
    mc_bus_regif_if.slave                           bus,
    output logic [REG_COUNT*MC_DATA_WIDTH-1:0]      o_cfg_q,
    output logic [MC_DATA_WIDTH-1:0]                o_cmd_data,
    output logic                                    o_cmd_push,
    input  wire logic                               i_cmd_full,
    input  wire logic [MC_DATA_WIDTH-1:0]           i_res_data,
    output logic                                    o_res_pop,
    input  wire logic                               i_res_empty
);

    localparam int                      c_NCFG      = REG_COUNT - 2;
    localparam logic [MC_ADD_WIDTH-1:0] c_STAT_ADDR = MC_ADD_WIDTH'(REG_COUNT - 2);
    localparam logic [MC_ADD_WIDTH-1:0] c_FIFO_ADDR = MC_ADD_WIDTH'(REG_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_COMMIT = 3'd2,
        S_RD     = 3'd3,
        S_RD_END = 3'd4
    } state_t;

    logic                     r_ce_m, r_we_m, r_oe_m;
    logic                     r_ce_s, r_we_s, r_oe_s;
    logic [MC_ADD_WIDTH-1:0]  r_add_s;
    logic [MC_DATA_WIDTH-1:0] r_dat_s;
    logic [1:0]               r_vld;
    logic                     r_armed;
    state_t                   r_state;
    state_t                   w_next;
    logic [MC_ADD_WIDTH-1:0]  r_acc_add;
    logic [MC_DATA_WIDTH-1:0] r_acc_dat;
    logic [MC_DATA_WIDTH-1:0] r_cfg [c_NCFG];
    logic                     r_ovf, r_unf;
    logic [MC_DATA_WIDTH-1:0] r_rdata;
    logic                     r_data_oe;
    logic [MC_DATA_WIDTH-1:0] r_cmd_data;
    logic                     r_cmd_push;
    logic                     r_res_pop;
    logic                     w_quiet;
    logic                     w_do_write;
    logic                     w_rd_done;
    logic                     w_oe_nxt;
    logic                     w_acc_stat, w_acc_fifo;
    logic                     w_push, w_drop, w_pop, w_under, w_stat_wr;
    logic [MC_DATA_WIDTH-1:0] w_status;
    logic [MC_DATA_WIDTH-1:0] w_rd_val;

    // Synchronisers idle high so a reset looks like "no strobe asserted"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_m  <= 1'b1;
            r_we_m  <= 1'b1;
            r_oe_m  <= 1'b1;
            r_ce_s  <= 1'b1;
            r_we_s  <= 1'b1;
            r_oe_s  <= 1'b1;
            r_add_s <= '0;
            r_dat_s <= '0;
        end else begin
            r_ce_m  <= bus.mc_ce;
            r_we_m  <= bus.mc_we;
            r_oe_m  <= bus.mc_oe;
            r_ce_s  <= r_ce_m;
            r_we_s  <= r_we_m;
            r_oe_s  <= r_oe_m;
            r_add_s <= bus.mc_add;
            r_dat_s <= bus.mc_data_i;
        end
    end

    // Accesses are only accepted once the bus has been seen quiet after reset,
    // so a strobe held low across reset release cannot start a spurious access.
    assign w_quiet = r_ce_s | (r_we_s & r_oe_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & w_quiet);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_do_write = 1'b0;
        w_rd_done  = 1'b0;
        w_oe_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !r_ce_s && !r_we_s) begin
                    w_next = S_WR;
                end else if (r_armed && !r_ce_s && !r_oe_s) begin
                    w_next = S_RD;
                end
            end
            S_WR: begin
                if (r_we_s || r_ce_s) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_do_write = 1'b1;
                w_next     = S_IDLE;
            end
            S_RD: begin
                if (r_oe_s || r_ce_s) begin
                    w_next    = S_RD_END;
                    w_rd_done = 1'b1;
                end else begin
                    w_oe_nxt  = 1'b1;
                end
            end
            S_RD_END: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_add <= '0;
            r_acc_dat <= '0;
        end else if (r_state == S_IDLE || r_state == S_WR || r_state == S_RD) begin
            r_acc_add <= r_add_s;
            r_acc_dat <= r_dat_s;
        end
    end

    assign w_acc_stat = (r_acc_add == c_STAT_ADDR);
    assign w_acc_fifo = (r_acc_add == c_FIFO_ADDR);
    assign w_stat_wr  = w_do_write & w_acc_stat;
    assign w_push     = w_do_write & w_acc_fifo & ~i_cmd_full;
    assign w_drop     = w_do_write & w_acc_fifo & i_cmd_full;
    assign w_pop      = w_rd_done & w_acc_fifo & ~i_res_empty;
    assign w_under    = w_rd_done & w_acc_fifo & i_res_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NCFG; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (w_do_write) begin
            for (int i = 0; i < c_NCFG; i++) begin
                if (r_acc_add == MC_ADD_WIDTH'(i)) begin
                    r_cfg[i] <= r_acc_dat;
                end
            end
        end
    end

    // Sticky flags: a new event wins over a simultaneous W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_drop  | (r_ovf & ~(w_stat_wr & r_acc_dat[2]));
            r_unf <= w_under | (r_unf & ~(w_stat_wr & r_acc_dat[3]));
        end
    end

`ifdef MC_BUS_ERRCNT_EN
    logic [7:0] r_errcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errcnt <= 8'd0;
        end else if (w_stat_wr && r_acc_dat[8]) begin
            r_errcnt <= 8'd0;
        end else if ((w_drop || w_under) && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end
`endif

    always_comb begin
        w_status    = '0;
        w_status[0] = i_cmd_full;
        w_status[1] = i_res_empty;
        w_status[2] = r_ovf;
        w_status[3] = r_unf;
`ifdef MC_BUS_ERRCNT_EN
        w_status[15:8] = r_errcnt;
`endif
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < c_NCFG; i++) begin
            if (r_add_s == MC_ADD_WIDTH'(i)) begin
                w_rd_val = r_cfg[i];
            end
        end
        if (r_add_s == c_STAT_ADDR) begin
            w_rd_val = w_status;
        end else if (r_add_s == c_FIFO_ADDR) begin
            w_rd_val = i_res_empty ? '0 : i_res_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= '0;
            r_data_oe  <= 1'b0;
            r_cmd_data <= '0;
            r_cmd_push <= 1'b0;
            r_res_pop  <= 1'b0;
        end else begin
            if (r_state == S_RD) begin
                r_rdata <= w_rd_val;
            end
            r_data_oe  <= w_oe_nxt;
            r_cmd_push <= w_push;
            r_res_pop  <= w_pop;
            if (w_push) begin
                r_cmd_data <= r_acc_dat;
            end
        end
    end

    assign bus.mc_data_o  = r_rdata;
    assign bus.mc_data_oe = r_data_oe;
    assign o_cmd_data     = r_cmd_data;
    assign o_cmd_push     = r_cmd_push;
    assign o_res_pop      = r_res_pop;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_cfgq
        if (g < c_NCFG) begin : g_reg
            assign o_cfg_q[g*MC_DATA_WIDTH +: MC_DATA_WIDTH] = r_cfg[g];
        end else begin : g_zero
            assign o_cfg_q[g*MC_DATA_WIDTH +: MC_DATA_WIDTH] = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_bus_regif.sv
// ============================================================================
// Module : tb_mc_bus_regif
// Brief  : Self-checking bench: directed table, reset abort, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_bus_regif;

`ifdef MC_BUS_ERRCNT_EN
    localparam bit c_EC = 1'b1;
`else
    localparam bit c_EC = 1'b0;
`endif
    localparam logic [15:0] c_E8 = c_EC ? 16'h0100 : 16'h0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] cfg_q;
    logic [15:0]  cmd_data;
    logic         cmd_push;
    logic         cmd_full = 1'b0;
    logic [15:0]  res_data = '0;
    logic         res_pop;
    logic         res_empty = 1'b1;

    mc_bus_regif_if #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) bus ();

    mc_bus_regif #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6), .REG_COUNT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_cfg_q    (cfg_q),
        .o_cmd_data (cmd_data),
        .o_cmd_push (cmd_push),
        .i_cmd_full (cmd_full),
        .i_res_data (res_data),
        .o_res_pop  (res_pop),
        .i_res_empty(res_empty)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_push  = 0;
    int          n_pop   = 0;
    logic [15:0] last_push = '0;

    always @(negedge clk) begin
        if (cmd_push) begin
            n_push    <= n_push + 1;
            last_push <= cmd_data;
        end
        if (res_pop) n_pop <= n_pop + 1;
    end

    // Reference model: plain register-file view of the block
    logic [15:0] m_cfg [6];
    bit          m_ovf, m_unf;
    int          m_ec;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_cfg[i] = '0;
        m_ovf = 0;
        m_unf = 0;
        m_ec  = 0;
    endtask

    task automatic model_op(input bit wr, input logic [5:0] a, input logic [15:0] d,
                            input bit full, input bit empty, input logic [15:0] rdat,
                            output logic [15:0] exp_rd, output int exp_push, output int exp_pop);
        exp_rd = '0; exp_push = 0; exp_pop = 0;
        if (wr) begin
            if (a < 6) m_cfg[a] = d;
            else if (a == 6) begin
                if (d[2]) m_ovf = 0;
                if (d[3]) m_unf = 0;
                if (c_EC && d[8]) m_ec = 0;
            end else if (a == 7) begin
                if (!full) exp_push = 1;
                else begin
                    m_ovf = 1;
                    if (c_EC && m_ec < 255) m_ec++;
                end
            end
        end else begin
            if (a < 6) exp_rd = m_cfg[a];
            else if (a == 6) exp_rd = {m_ec[7:0], 4'h0, m_unf, m_ovf, empty, full};
            else if (a == 7) begin
                if (empty) begin
                    m_unf = 1;
                    if (c_EC && m_ec < 255) m_ec++;
                end else begin
                    exp_rd  = rdat;
                    exp_pop = 1;
                end
            end
        end
    endtask

    function automatic logic [127:0] model_cfg();
        logic [127:0] v = '0;
        for (int i = 0; i < 6; i++) v[i*16 +: 16] = m_cfg[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input bit wr, input logic [5:0] a, input logic [15:0] d,
                          input bit full, input bit empty, input logic [15:0] rdat, input int hold,
                          output logic [15:0] rd, output logic oe_seen,
                          output int pushes, output int pops);
        int p0, q0;
        p0 = n_push; q0 = n_pop;
        bus.mc_add = a; bus.mc_data_i = d;
        cmd_full = full; res_empty = empty; res_data = rdat;
        repeat (3) @(negedge clk);
        bus.mc_ce = 1'b0;
        if (wr) bus.mc_we = 1'b0; else bus.mc_oe = 1'b0;
        repeat (hold) @(negedge clk);
        rd = bus.mc_data_o; oe_seen = bus.mc_data_oe;
        bus.mc_we = 1'b1; bus.mc_oe = 1'b1; bus.mc_ce = 1'b1;
        repeat (8) @(negedge clk);
        pushes = n_push - p0; pops = n_pop - q0;
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  a;
        logic [15:0] d;
        bit          full;
        bit          empty;
        logic [15:0] rdat;
        int          hold;
        logic [15:0] exp_rd;
        int          exp_push;
        int          exp_pop;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [5:0] a, logic [15:0] d, bit full, bit empty,
                                logic [15:0] rdat, int hold, logic [15:0] exp_rd,
                                int exp_push, int exp_pop);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.full = full; v.empty = empty; v.rdat = rdat;
        v.hold = hold; v.exp_rd = exp_rd; v.exp_push = exp_push; v.exp_pop = exp_pop;
        return v;
    endfunction

    task automatic do_checked(input string tag, input bit wr, input logic [5:0] a,
                              input logic [15:0] d, input bit full, input bit empty,
                              input logic [15:0] rdat, input int hold,
                              input bit use_tbl, input logic [15:0] t_rd,
                              input int t_push, input int t_pop);
        logic [15:0] rd, e_rd;
        logic        oe_seen;
        int          pushes, pops, e_push, e_pop;
        model_op(wr, a, d, full, empty, rdat, e_rd, e_push, e_pop);
        if (use_tbl) begin
            e_rd = t_rd; e_push = t_push; e_pop = t_pop;
        end
        run_op(wr, a, d, full, empty, rdat, hold, rd, oe_seen, pushes, pops);
        if (!wr) begin
            chk({tag, " rdata"}, 128'(rd), 128'(e_rd));
            chk({tag, " oe_during"}, 128'(oe_seen), 128'(1'b1));
        end
        chk({tag, " push_cnt"}, 128'(pushes), 128'(e_push));
        chk({tag, " pop_cnt"}, 128'(pops), 128'(e_pop));
        if (wr && pushes == 1) chk({tag, " push_data"}, 128'(last_push), 128'(d));
        chk({tag, " oe_after"}, 128'(bus.mc_data_oe), 128'(1'b0));
        chk({tag, " cfg_q"}, cfg_q, model_cfg());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        int          p0;
        logic [5:0]  ra;

        bus.mc_ce = 1'b1; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
        bus.mc_add = '0; bus.mc_data_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset cfg_q", cfg_q, 128'd0);
        chk("reset outs", 128'({cmd_push, res_pop, bus.mc_data_oe, bus.mc_data_o, cmd_data}), 128'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        //            wr a      d        full empty rdat     hold exp_rd            push pop
        tbl.push_back(mk(1, 6'd0,  16'h00FB, 0, 1, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(1, 6'd1,  16'h0004, 0, 1, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd0,  16'h0000, 0, 1, 16'h0000, 6,  16'h00FB,          0, 0));
        tbl.push_back(mk(0, 6'd1,  16'h0000, 0, 1, 16'h0000, 6,  16'h0004,          0, 0));
        tbl.push_back(mk(1, 6'd7,  16'h08AA, 0, 1, 16'h0000, 6,  16'h0000,          1, 0));
        tbl.push_back(mk(1, 6'd7,  16'h08FF, 0, 1, 16'h0000, 6,  16'h0000,          1, 0));
        tbl.push_back(mk(1, 6'd7,  16'h0800, 0, 1, 16'h0000, 6,  16'h0000,          1, 0));
        tbl.push_back(mk(1, 6'd7,  16'h81FF, 1, 1, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd6,  16'h0000, 1, 1, 16'h0000, 6,  c_E8 | 16'h0007,   0, 0));
        tbl.push_back(mk(1, 6'd6,  16'h0104, 0, 0, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd6,  16'h0000, 0, 0, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd7,  16'h0000, 0, 0, 16'h1234, 10, 16'h1234,          0, 1));
        tbl.push_back(mk(0, 6'd7,  16'h0000, 0, 1, 16'h1234, 10, 16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd6,  16'h0000, 0, 1, 16'h0000, 6,  c_E8 | 16'h000A,   0, 0));
        tbl.push_back(mk(1, 6'd6,  16'h0008, 0, 0, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd6,  16'h0000, 0, 0, 16'h0000, 6,  c_E8,              0, 0));
        tbl.push_back(mk(1, 6'h20, 16'h1111, 0, 0, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'h20, 16'h0000, 0, 0, 16'h0000, 6,  16'h0000,          0, 0));
        tbl.push_back(mk(0, 6'd0,  16'h0000, 0, 0, 16'h0000, 6,  16'h00FB,          0, 0));

        foreach (tbl[i]) begin
            do_checked($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].full,
                       tbl[i].empty, tbl[i].rdat, tbl[i].hold, 1'b1, tbl[i].exp_rd,
                       tbl[i].exp_push, tbl[i].exp_pop);
        end

        // Reset in the middle of a FIFO write, strobes held low across release
        bus.mc_add = 6'd7; bus.mc_data_i = 16'hBEEF; cmd_full = 1'b0;
        repeat (3) @(negedge clk);
        bus.mc_ce = 1'b0; bus.mc_we = 1'b0;
        repeat (3) @(negedge clk);
        p0 = n_push;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("midrst cfg_q", cfg_q, 128'd0);
        chk("midrst outs", 128'({cmd_push, res_pop, bus.mc_data_oe, bus.mc_data_o, cmd_data}), 128'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst held_push", 128'(n_push - p0), 128'd0);
        bus.mc_we = 1'b1; bus.mc_ce = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst release_push", 128'(n_push - p0), 128'd0);
        do_checked("postrst", 1'b1, 6'd7, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 6, 1'b0, '0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            do_checked($sformatf("rnd%0d", i), 1'($urandom), ra, 16'($urandom),
                       1'($urandom_range(0, 2) == 0), 1'($urandom), 16'($urandom),
                       int'($urandom_range(6, 9)), 1'b0, '0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
